f1_light_ctrl: RTL and testbench

F1_LIGHT_CTRL -- requirements
Module: f1_light_ctrl

---
 rtl/f1_light_ctrl.sv | 102 ++++++++++
 tb/tb_f1_light_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/f1_light_ctrl.sv
// rtl/f1_light_ctrl.sv - F1 start-light sequencer with random hold delay; optional abort via F1_LIGHT_ABORT_EN
module f1_light_ctrl #(
  parameter int N_LIGHTS = 8,
  parameter int RND_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic [RND_W-1:0]    rnd,
`ifdef F1_LIGHT_ABORT_EN
  input  logic                abort,
`endif
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                go,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [N_LIGHTS-1:0]  data_n;
  logic [RND_W-1:0]     cnt, cnt_n;
  logic                 go_n;
  logic                 abort_req;

`ifdef F1_LIGHT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      go       <= 1'b0;
      busy     <= 1'b0;
      lfsr_en  <= 1'b1;
    end else begin
      state    <= state_n;
      data_out <= data_n;
      cnt      <= cnt_n;
      go       <= go_n;
      busy     <= (state_n != IDLE);
      lfsr_en  <= (state_n == IDLE);
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_out;
    cnt_n   = cnt;
    go_n    = 1'b0;
    case (state)
      IDLE: begin
        // A trigger consumes the cycle; a coincident en does not light a lamp.
        data_n = '0;
        if (trigger) begin
          state_n = LIGHTS;
        end
      end
      LIGHTS: begin
        if (en) begin
          data_n = {data_out[N_LIGHTS-2:0], 1'b1};
          if (&data_out[N_LIGHTS-2:0]) begin
            state_n = HOLD;
            cnt_n   = (rnd == '0) ? RND_W'(1) : rnd;
          end
        end
      end
      HOLD: begin
        if (en) begin
          cnt_n = cnt - RND_W'(1);
          if (cnt == RND_W'(1)) begin
            data_n  = '0;
            go_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        data_n  = '0;
      end
    endcase
    // Abort outranks en and never produces a go pulse.
    if (abort_req && (state != IDLE)) begin
      state_n = IDLE;
      data_n  = '0;
      cnt_n   = '0;
      go_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_f1_light_ctrl.sv
// tb/tb_f1_light_ctrl.sv - directed self-checking bench for f1_light_ctrl
module tb_f1_light_ctrl;
  localparam int N  = 8;
  localparam int RW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          trigger;
  logic [RW-1:0] rnd;
`ifdef F1_LIGHT_ABORT_EN
  logic          abort;
`endif
  logic          lfsr_en;
  logic [N-1:0]  data_out;
  logic          go;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  f1_light_ctrl #(.N_LIGHTS(N), .RND_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trigger  (trigger),
    .rnd      (rnd),
`ifdef F1_LIGHT_ABORT_EN
    .abort    (abort),
`endif
    .lfsr_en  (lfsr_en),
    .data_out (data_out),
    .go       (go),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given en/trigger, then sample 1 ns after the edge.
  task automatic step(input logic e, input logic t);
    en      = e;
    trigger = t;
    @(posedge clk);
    #1;
    en      = 1'b0;
    trigger = 1'b0;
  endtask

  function automatic logic [31:0] lamps(input int k);
    return (32'h1 << k) - 32'h1;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; trigger = 1'b0; rnd = '0;
`ifdef F1_LIGHT_ABORT_EN
    abort = 1'b0;
`endif
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_data", data_out, 0);
    chk("rst_go", go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr_en", lfsr_en, 1);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("idle_data", data_out, 0);
      chk("idle_go", go, 0);
      chk("idle_busy", busy, 0);
      chk("idle_lfsr_en", lfsr_en, 1);
    end

    // Full sequence, rnd=3, en every 4th cycle
    rnd = 7'd3;
    step(1'b0, 1'b1);
    chk("trig_busy", busy, 1);
    chk("trig_data", data_out, 0);
    chk("trig_lfsr_en", lfsr_en, 0);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) step(1'b0, 1'b0);
      chk("lights_freeze", data_out, lamps(k - 1));
      step(1'b1, 1'b0);
      chk("lights_data", data_out, lamps(k));
      chk("lights_go", go, 0);
    end
    rnd = 7'd7;
    for (int h = 1; h <= 2; h++) begin
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("hold_data", data_out, 32'hFF);
      chk("hold_go", go, 0);
      chk("hold_busy", busy, 1);
      chk("hold_lfsr_en", lfsr_en, 0);
    end
    repeat (3) step(1'b0, 1'b0);
    chk("hold_freeze_go", go, 0);
    step(1'b1, 1'b0);
    chk("go_pulse", go, 1);
    chk("go_data", data_out, 0);
    chk("go_busy", busy, 0);
    step(1'b0, 1'b0);
    chk("go_end", go, 0);
    chk("post_lfsr_en", lfsr_en, 1);

    // rnd=0 loads a delay of one tick
    rnd = 7'd0;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0);
    chk("rnd0_full", data_out, 32'hFF);
    chk("rnd0_nogo", go, 0);
    step(1'b1, 1'b0);
    chk("rnd0_go", go, 1);
    chk("rnd0_data", data_out, 0);
    step(1'b0, 1'b0);

    // trigger+en together in IDLE, then trigger held throughout
    rnd = 7'd2;
    step(1'b1, 1'b1);
    chk("trigen_data", data_out, 0);
    chk("trigen_busy", busy, 1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      chk("retrig_data", data_out, lamps(k));
    end
    step(1'b1, 1'b1);
    chk("retrig_hold_go", go, 0);
    chk("retrig_hold_data", data_out, 32'hFF);
    step(1'b1, 1'b1);
    chk("retrig_go", go, 1);
    chk("retrig_busy", busy, 0);
    step(1'b0, 1'b0);
    chk("retrig_go_end", go, 0);
    chk("retrig_idle", busy, 0);

    // Reset mid-LIGHTS at 0x1F
    rnd = 7'd1;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0);
    chk("pre_rst_data", data_out, 32'h1F);
    rst = 1'b1;
    step(1'b1, 1'b0);
    chk("midrst_data", data_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_go", go, 0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("midrst_lfsr_en", lfsr_en, 1);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0);
      chk("midrst_nogo", go, 0);
      chk("midrst_dark", data_out, 0);
    end

`ifdef F1_LIGHT_ABORT_EN
    // Abort with en during HOLD
    rnd = 7'd4;
    step(1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) step(1'b1, 1'b0);
    chk("abort_pre_data", data_out, 32'hFF);
    abort = 1'b1;
    step(1'b1, 1'b0);
    abort = 1'b0;
    chk("abort_data", data_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_go", go, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      chk("abort_nogo", go, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
